reconfig_sequencer: RTL
=======================

# reconfig_sequencer

Sequences runtime reconfiguration of the instrumentation chain (packer, filters and the other firmware-driven trace blocks). The host loads a shadow image of per-block firmware bytes, then pulses `start`. The sequencer suspends tracing, streams the image onto the shared `configId`/`configData` bus one byte per cycle, and resumes tracing. It is the only driver of the chain's `tracing`, `configId` and `configData` signals.

## Interface
Parameters:
- `MAX_CHAINS`, 4: chains per block; each block takes `BPB = 2*MAX_CHAINS` bytes.
- `NUM_BLOCKS`, 4: number of configurable blocks. Block b owns config ID b.
- `DRAIN_CYCLES`, 4: quiet cycles before streaming; must be ≥1.
- `IDLE_ID`, 8'hFF: config ID driven whenever no byte is being delivered; must be ≥ `NUM_BLOCKS`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `tracing_en` in 1: host request for tracing while not reconfiguring.
- `wr_en` in 1: shadow write strobe.
- `wr_addr` in clog2(NUM_BLOCKS*BPB): shadow byte address.
- `wr_data` in 8: shadow byte.
- `start` in 1: single-cycle reconfiguration request.
- `tracing` out 1: to every instrumentation block.
- `configId` out 8: target block ID.
- `configData` out 8: byte for the target block.
- `busy` out 1: reconfiguration in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- **Shadow image:**
  - Holds NUM_BLOCKS×BPB bytes. Address = b*BPB + k.
  - For k < MAX_CHAINS, byte k is the condition byte for chain k.
  - Otherwise byte k is the firmware byte for chain k−MAX_CHAINS.
  - Cleared to 0 on reset.
  - `wr_en` is honoured only when `busy`=0 and is ignored otherwise (no error flag).
- **FSM states:** IDLE → DRAIN → STREAM → RESUME → IDLE.
  - **IDLE:** `tracing`=`tracing_en` (registered), `configId`=IDLE_ID, `busy`=0. `start`=1 → DRAIN.
  - **DRAIN:** `tracing`=0, `configId`=IDLE_ID, `busy`=1. A down-counter runs DRAIN_CYCLES cycles, then → STREAM. This forces every block's byte counter to reset (its ID does not match) and drops any in-flight valid beats.
  - **STREAM:** `tracing`=0. Each cycle drives `configId`=b and `configData`=shadow[b*BPB+k].
    - k increments; on k=BPB−1, k wraps to 0 and b increments.
    - After b=NUM_BLOCKS−1, k=BPB−1 → RESUME.
    - Bytes go in strictly ascending address order, with no gaps.
  - **RESUME:** one cycle with `tracing`=0, `configId`=IDLE_ID, `configData`=0, `done`=1 → IDLE.
- `configData`=0 whenever not in STREAM.
- `start` is ignored while `busy`=1.
- `start` and `wr_en` in the same IDLE cycle: the write lands first and is included in the streamed image.
- A `tracing_en` change during a sequence has no effect until IDLE.
- **Reset mid-sequence:** the FSM returns to IDLE immediately and the shadow is cleared. The partially configured chain is not repaired; the host must reload the shadow and restart.

## Timing
- All outputs are registered.
- **Reset values:** `tracing`=0, `configId`=IDLE_ID, `configData`=0, `busy`=0, `done`=0. The first post-reset IDLE cycle after `rst` falls drives `tracing`=`tracing_en` on the following edge.
- **Sequence timeline**, with `start` sampled at edge t and S = NUM_BLOCKS×BPB:
  - `busy`=1 and `tracing`=0 from cycle t+1.
  - DRAIN occupies t+1..t+DRAIN_CYCLES.
  - Bytes appear at t+DRAIN_CYCLES+1 .. t+DRAIN_CYCLES+S.
  - `done`=1 at t+DRAIN_CYCLES+S+1.
  - `busy`=0 and `tracing`=`tracing_en` at t+DRAIN_CYCLES+S+2.
- **Default parameters:** bytes at t+5..t+36, `done` at t+37, tracing restored at t+38.
- IDLE `tracing` follows `tracing_en` with 1-cycle latency.

## Structure
- Package `lebug_cfg_pkg` holds:
  - the state enum (`CFG_IDLE`, `CFG_DRAIN`, `CFG_STREAM`, `CFG_RESUME`);
  - `IDLE_ID`;
  - a `cfg_byte_t` typedef (8 bits).
- One sub-module, `cfg_shadow_ram`:
  - S×8 register array;
  - synchronous write, combinational read;
  - synchronous clear on `rst`.
  - The read address comes from the FSM's b/k counters.
- FSM, drain counter, b/k counters and output registers stay in `reconfig_sequencer`.

## Test plan
- **Reset then IDLE:** assert `rst` 2 cycles with `tracing_en`=1. Outputs hold their reset values during reset; `tracing`=1 one cycle after the first IDLE edge; `configId`=8'hFF.
- **Full sequence (defaults):** write shadow[a]=a for a=0..31, then pulse `start` at t. Required: `tracing`=0 at t+1; (configId, configData) = (0,0)…(0,7),(1,8)…(3,31) on t+5..t+36; `done` only at t+37; `tracing`=1 and `busy`=0 at t+38.
- **Busy lockout:** during STREAM, issue `wr_en` to addr 3 with data 8'hAA and a second `start`. Shadow[3] is unchanged at the next sequence; no restart occurs; `done` pulses exactly once.
- **Same-cycle write+start:** in IDLE, write addr 0 = 8'h5C together with `start`. The first streamed byte is (0, 8'h5C).
- **Reset mid-STREAM:** assert `rst` at byte 10. Next cycle `configId`=8'hFF, `busy`=0, `done`=0, and all shadow bytes read 0 on a subsequent sequence.
- **tracing_en toggled:** drop `tracing_en` during DRAIN. After RESUME, `tracing` stays 0; raising `tracing_en` in IDLE gives `tracing`=1 one cycle later.

Source files
------------

// File: rtl/lebug_cfg_pkg.sv
// Shared types and constants for the instrumentation-chain reconfiguration logic.
package lebug_cfg_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_DRAIN,
    CFG_STREAM,
    CFG_RESUME
  } cfg_state_t;

  typedef logic [7:0] cfg_byte_t;

  localparam cfg_byte_t IDLE_ID = 8'hFF;

endpackage

// File: rtl/cfg_shadow_ram.sv
// Shadow image of per-block firmware bytes: synchronous write and clear,
// combinational read addressed by the sequencer's block/byte counters.
module cfg_shadow_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  import lebug_cfg_pkg::*;

  cfg_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/reconfig_sequencer.sv
// Suspends tracing, streams the shadow image onto configId/configData one
// byte per cycle in ascending address order, then restores tracing.
module reconfig_sequencer #(
  parameter int unsigned MAX_CHAINS   = 4,
  parameter int unsigned NUM_BLOCKS   = 4,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [7:0]  IDLE_ID      = 8'hFF,
  localparam int unsigned BPB = 2 * MAX_CHAINS,
  localparam int unsigned S   = NUM_BLOCKS * BPB,
  localparam int unsigned AW  = (S > 1) ? $clog2(S) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tracing_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  output logic          tracing,
  output logic [7:0]    configId,
  output logic [7:0]    configData,
  output logic          busy,
  output logic          done
);
  import lebug_cfg_pkg::*;

  localparam int unsigned BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned KW = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  cfg_state_t    state, state_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [BW-1:0] b, b_n;
  logic [KW-1:0] k, k_n;
  logic [AW-1:0] rd_addr;
  cfg_byte_t     rd_data;
  logic          last;
  logic          tracing_n, busy_n, done_n;
  cfg_byte_t     id_n, data_n;

  cfg_shadow_ram #(
    .DEPTH (S),
    .AW    (AW)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en & ~busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign last = (b == BW'(NUM_BLOCKS - 1)) && (k == KW'(BPB - 1));

  // b/k name the byte currently on the bus; b_n/k_n (and thus rd_addr) the
  // byte registered at the next edge. Kept apart from the FSM to avoid a
  // combinational block that both feeds and consumes the RAM read port.
  always_comb begin
    b_n = b;
    k_n = k;
    case (state)
      CFG_IDLE: begin
        b_n = '0;
        k_n = '0;
      end
      CFG_STREAM: begin
        if (!last) begin
          if (k == KW'(BPB - 1)) begin
            k_n = '0;
            b_n = b + 1'b1;
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign rd_addr = AW'(b_n) * AW'(BPB) + AW'(k_n);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tracing_n = 1'b0;
    id_n      = IDLE_ID;
    data_n    = '0;
    busy_n    = 1'b1;
    done_n    = 1'b0;
    case (state)
      CFG_IDLE: begin
        if (start) begin
          state_n = CFG_DRAIN;
          cnt_n   = DW'(DRAIN_CYCLES - 1);
        end else begin
          busy_n    = 1'b0;
          tracing_n = tracing_en;
        end
      end
      CFG_DRAIN: begin
        if (cnt == '0) begin
          state_n = CFG_STREAM;
          id_n    = 8'(b_n);
          data_n  = rd_data;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      CFG_STREAM: begin
        if (last) begin
          state_n = CFG_RESUME;
          done_n  = 1'b1;
        end else begin
          id_n   = 8'(b_n);
          data_n = rd_data;
        end
      end
      CFG_RESUME: begin
        state_n   = CFG_IDLE;
        busy_n    = 1'b0;
        tracing_n = tracing_en;
      end
      default: begin
        state_n = CFG_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CFG_IDLE;
      cnt        <= '0;
      b          <= '0;
      k          <= '0;
      tracing    <= 1'b0;
      configId   <= IDLE_ID;
      configData <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      b          <= b_n;
      k          <= k_n;
      tracing    <= tracing_n;
      configId   <= id_n;
      configData <= data_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule
